lsu_bus_if: RTL and testbench

LSU_BUS_IF -- requirements
Module: lsu_bus_if

---
 rtl/lsu_bus_if.sv | 183 ++++++++++++++++++
 tb/tb_lsu_bus_if.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if.sv
// Load/store unit bus interface: IDLE/REQ/DONE handshake with byte-lane formatting.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_bus_if (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdo,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        misalign
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic        req_s;
   logic        mis_s;
   logic        issue_s;
   logic [3:0]  wstrb_s;
   logic [31:0] wdata_fmt_s;
   logic        load_r;
   logic [2:0]  funct3_r;
   logic [1:0]  off_r;

   function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'h000000, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'h0000, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // A store wins when both request lines are high.
   assign req_s   = mem_rd | mem_wr;
   assign issue_s = (state_r == ST_IDLE) && req_s && !mis_s;

`ifdef LSU_MISALIGN_CHK_EN
   logic misalign_r;

   assign mis_s = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

   // Misalign flag is high only during the DONE cycle that follows a trapped request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_r <= 1'b0;
      end else begin
         misalign_r <= (state_r == ST_IDLE) && req_s && mis_s;
      end
   end

   assign misalign = misalign_r;
`else
   assign mis_s    = 1'b0;
   assign misalign = 1'b0;
`endif

   // Store lane steering: byte/half replicated, strobes select the addressed lanes.
   always_comb begin
      wstrb_s     = 4'b0000;
      wdata_fmt_s = wdata;
      case (funct3[1:0])
         2'b00: begin
            wstrb_s     = 4'b0001 << addr[1:0];
            wdata_fmt_s = {4{wdata[7:0]}};
         end
         2'b01: begin
            wstrb_s     = 4'b0011 << {addr[1], 1'b0};
            wdata_fmt_s = {2{wdata[15:0]}};
         end
         default: begin
            wstrb_s     = 4'b1111;
            wdata_fmt_s = wdata;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; DONE always returns to IDLE so a held request is not re-issued.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_s) begin
               if (mis_s) begin
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_REQ;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus_ack) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_REQ;
            end
         end
         ST_DONE: next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Stall output decode.
   always_comb begin
      stall = 1'b0;
      case (state_r)
         ST_IDLE: stall = req_s;
         ST_REQ:  stall = 1'b1;
         ST_DONE: stall = 1'b0;
         default: stall = 1'b0;
      endcase
   end

   // Bus launch on issue, load data capture on the acknowledged REQ edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdo       <= 32'h0000_0000;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0000_0000;
         bus_wstrb <= 4'b0000;
         bus_wdata <= 32'h0000_0000;
         load_r    <= 1'b0;
         funct3_r  <= 3'b000;
         off_r     <= 2'b00;
      end else if (issue_s) begin
         bus_req   <= 1'b1;
         bus_we    <= mem_wr;
         bus_addr  <= {addr[31:2], 2'b00};
         bus_wstrb <= mem_wr ? wstrb_s : 4'b0000;
         bus_wdata <= wdata_fmt_s;
         load_r    <= ~mem_wr;
         funct3_r  <= funct3;
         off_r     <= addr[1:0];
      end else if ((state_r == ST_REQ) && bus_ack) begin
         bus_req <= 1'b0;
         if (load_r) begin
            rdo <= fmt_load(funct3_r, off_r, bus_rdata);
         end
      end
   end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Self-checking bench for lsu_bus_if: scoreboard of expected bus cycles and load results.
module tb_lsu_bus_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_rd, mem_wr;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic [31:0] rdo;
   logic        stall, bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        misalign;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] last_rdo = 32'h0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] rdo;
      int          stall_cyc;
   } exp_t;

   exp_t sbq[$];

   lsu_bus_if dut (
      .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdo(rdo), .stall(stall), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .misalign(misalign)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic we, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d, input logic [31:0] r, input int sc);
      exp_t e;
      e.we = we; e.addr = a; e.wstrb = s; e.wdata = d; e.rdo = r; e.stall_cyc = sc;
      return e;
   endfunction

   // Reference load formatter built from shifts.
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      logic [31:0] sb, shh;
      sb  = w >> (a[1:0] * 8);
      shh = w >> (a[1] * 16);
      if (f3 == 3'b000)      return {{24{sb[7]}}, sb[7:0]};
      else if (f3 == 3'b100) return sb & 32'h0000_00FF;
      else if (f3 == 3'b001) return {{16{shh[15]}}, shh[15:0]};
      else if (f3 == 3'b101) return shh & 32'h0000_FFFF;
      else                   return w;
   endfunction

   task automatic run_access(input string name, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdata, input int ack_lat, input exp_t e);
      exp_t cur;
      int   stall_cnt = 0;
      int   req_cnt = 0;
      bit   done = 1'b0;
      sbq.push_back(e);
      mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd; bus_rdata = rdata;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (stall) begin
            stall_cnt++;
            if (bus_req) begin
               req_cnt++;
               n_checks++;
               if (bus_we !== sbq[0].we || bus_addr !== sbq[0].addr || bus_wstrb !== sbq[0].wstrb ||
                   (sbq[0].we && bus_wdata !== sbq[0].wdata)) begin
                  n_fail++;
                  $display("FAIL %s bus: we=%0b addr=%h wstrb=%b wdata=%h required we=%0b addr=%h wstrb=%b wdata=%h",
                           name, bus_we, bus_addr, bus_wstrb, bus_wdata,
                           sbq[0].we, sbq[0].addr, sbq[0].wstrb, sbq[0].wdata);
               end
               bus_ack = (req_cnt == ack_lat);
            end else begin
               bus_ack = 1'b0;
            end
         end else begin
            done    = 1'b1;
            bus_ack = 1'b0;
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s timeout: stall still high after 40 cycles, required DONE", name);
         void'(sbq.pop_front());
      end else begin
         cur = sbq.pop_front();
         n_fail += 0;
         if (rdo !== cur.rdo) begin
            n_fail++;
            $display("FAIL %s rdo: got %h required %h", name, rdo, cur.rdo);
         end
         n_checks++;
         if (stall_cnt != cur.stall_cyc || req_cnt != ack_lat) begin
            n_fail++;
            $display("FAIL %s timing: stall cycles %0d bus_req cycles %0d required %0d and %0d",
                     name, stall_cnt, req_cnt, cur.stall_cyc, ack_lat);
         end
         n_checks++;
         if (bus_req !== 1'b0 || misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done: bus_req=%0b misalign=%0b required 0 0", name, bus_req, misalign);
         end
      end
      @(posedge clk); #1;
      mem_rd = 1'b0; mem_wr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000; addr = 32'h0;
      wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({rdo, bus_addr, bus_wdata} !== 96'h0) begin
         n_fail++;
         $display("FAIL reset data: rdo=%h bus_addr=%h bus_wdata=%h required 0", rdo, bus_addr, bus_wdata);
      end
      n_checks++;
      if ({bus_req, bus_we, bus_wstrb, misalign, stall} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset ctrl: req=%0b we=%0b wstrb=%b mis=%0b stall=%0b required 0",
                  bus_req, bus_we, bus_wstrb, misalign, stall);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_loads();
      run_access("lw_0x100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1,
                 mk(1'b0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF, 2));
      run_access("lb_0x103", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1,
                 mk(1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFF80, 2));
      run_access("lh_0x102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 2,
                 mk(1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFF80FF, 3));
      run_access("lhu_0x102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 1,
                 mk(1'b0, 32'h100, 4'b0000, 32'h0, 32'h000080FF, 2));
      run_access("lb_0x101", 1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF1234, 1,
                 mk(1'b0, 32'h100, 4'b0000, 32'h0, 32'h00000012, 2));
      run_access("lbu_0x103", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1,
                 mk(1'b0, 32'h100, 4'b0000, 32'h0, 32'h00000080, 2));
      last_rdo = 32'h00000080;
   endtask

   task automatic test_stores();
      run_access("sh_0x202", 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 1,
                 mk(1'b1, 32'h200, 4'b1100, 32'hABCDABCD, last_rdo, 2));
      run_access("sb_0x201", 1'b0, 1'b1, 3'b000, 32'h201, 32'h1234565A, 32'h0, 1,
                 mk(1'b1, 32'h200, 4'b0010, 32'h5A5A5A5A, last_rdo, 2));
      run_access("sw_0x204", 1'b0, 1'b1, 3'b010, 32'h204, 32'h12345678, 32'h0, 2,
                 mk(1'b1, 32'h204, 4'b1111, 32'h12345678, last_rdo, 3));
      run_access("rd_wr_both", 1'b1, 1'b1, 3'b010, 32'h208, 32'hCAFEF00D, 32'h55555555, 1,
                 mk(1'b1, 32'h208, 4'b1111, 32'hCAFEF00D, last_rdo, 2));
   endtask

   task automatic test_wait_states();
      run_access("lw_wait5", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h13579BDF, 5,
                 mk(1'b0, 32'h300, 4'b0000, 32'h0, 32'h13579BDF, 6));
      last_rdo = 32'h13579BDF;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         logic        st;
         logic [2:0]  f3;
         logic [31:0] a, wd, rw, exp_r;
         logic [3:0]  es;
         logic [31:0] ed;
         int          lat;
         st  = 1'($urandom_range(0, 1));
         a   = {20'h0, 12'($urandom_range(0, 4095))};
         wd  = $urandom;
         rw  = $urandom;
         lat = $urandom_range(1, 3);
         if (st) f3 = 3'($urandom_range(0, 2));
         else    f3 = (i % 5 == 0) ? 3'b000 : (i % 5 == 1) ? 3'b001 : (i % 5 == 2) ? 3'b010 :
                      (i % 5 == 3) ? 3'b100 : 3'b101;
         if (f3[1:0] == 2'b01) a[0] = 1'b0;
         if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         if (!st) begin
            es = 4'b0000; ed = 32'h0;
            exp_r = model_load(f3, a, rw);
         end else begin
            exp_r = last_rdo;
            if (f3 == 3'b000)      begin es = 4'b0001 << a[1:0];      ed = {4{wd[7:0]}};  end
            else if (f3 == 3'b001) begin es = 4'b0011 << (a[1] * 2);  ed = {2{wd[15:0]}}; end
            else                   begin es = 4'b1111;                ed = wd;            end
         end
         run_access("b2b", ~st, st, f3, a, wd, rw, lat,
                    mk(st, a & 32'hFFFF_FFFC, es, ed, exp_r, lat + 1));
         last_rdo = exp_r;
      end
   endtask

`ifdef LSU_MISALIGN_CHK_EN
   task automatic test_misalign();
      mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h101;
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b1 || bus_req !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign issue: stall=%0b bus_req=%0b required 1 0", stall, bus_req);
      end
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || misalign !== 1'b1 || bus_req !== 1'b0 || rdo !== last_rdo) begin
         n_fail++;
         $display("FAIL misalign done: stall=%0b mis=%0b req=%0b rdo=%h required 0 1 0 %h",
                  stall, misalign, bus_req, rdo, last_rdo);
      end
      @(posedge clk); #1;
      mem_rd = 1'b0;
      @(negedge clk);
      n_checks++;
      if (misalign !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign clear: mis=%0b stall=%0b required 0 0", misalign, stall);
      end
      @(posedge clk); #1;
   endtask
`else
   task automatic test_misalign();
      run_access("lw_0x106", 1'b1, 1'b0, 3'b010, 32'h106, 32'h0, 32'h11223344, 1,
                 mk(1'b0, 32'h104, 4'b0000, 32'h0, 32'h11223344, 2));
      run_access("lh_0x101", 1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0000F00F, 1,
                 mk(1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFFF00F, 2));
      last_rdo = 32'hFFFFF00F;
   endtask
`endif

   task automatic test_ack_ignored();
      bus_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus_req !== 1'b0 || stall !== 1'b0 || rdo !== last_rdo) begin
            n_fail++;
            $display("FAIL ack_idle: req=%0b stall=%0b rdo=%h required 0 0 %h",
                     bus_req, stall, rdo, last_rdo);
         end
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h300; bus_rdata = 32'h0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus_req !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid setup: bus_req=%0b required 1", bus_req);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus_req !== 1'b0 || rdo !== 32'h0 || bus_addr !== 32'h0 || bus_wstrb !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_mid: req=%0b rdo=%h addr=%h wstrb=%b required 0 0 0 0",
                  bus_req, rdo, bus_addr, bus_wstrb);
      end
      mem_rd = 1'b0;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid state: stall=%0b required 0", stall);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_rdo = 32'h0;
      run_access("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 1,
                 mk(1'b0, 32'h104, 4'b0000, 32'h0, 32'h0BADF00D, 2));
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_wait_states();
      test_misalign();
      test_ack_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
